memory_axil_lsu: RTL and testbench
==================================

# memory_axil_lsu

Parametrised load/store unit that turns one CPU memory request into a single AXI4-Lite master transaction with byte-lane steering. It handles write strobes, lane extraction and sign extension, misalignment detection, response-error reporting and a watchdog timeout. It sits between the CPU memory stage and any AXI4-Lite slave (RAM, MMIO interconnect) and exposes an external master port instead of embedding the RAM.

## Interface
- ADDR_WIDTH, 16: AXI address width; bus addresses use i_Addr[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 256: maximum cycles in any bus-waiting state before a fault; 0 disables the watchdog.
- Data width is fixed at XLEN = 32. LS_TYPE_* encodings and LS_SEL_WIDTH come from memory.vh.

Ports:
- i_Clock  in  1  sole clock; everything is rising-edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Request  in  1  request strobe; sampled only in IDLE.
- i_Load_Store_Type  in  LS_SEL_WIDTH+1  LS_TYPE_* code; latched on accept.
- i_Addr  in  XLEN  byte address; latched on accept.
- i_Data  in  XLEN  store data, right-aligned; latched on accept.
- o_Data  out  XLEN  registered load result; holds until the next load completes.
- o_Done  out  1  one-cycle pulse when a request finishes, either OK or faulted.
- o_Error  out  1  qualified by o_Done: misaligned access, nonzero RRESP/BRESP, or timeout.
- o_Busy  out  1  high whenever state != IDLE.
- o_State  out  3  current FSM state.
- m_axil_araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready: standard AXI4-Lite master signals. Address width is ADDR_WIDTH, data width 32, strobe width 4, resp width 2. AxPROT is not driven.

## Operation
- State encodings: IDLE=0, READ_SUBMITTING=1, READ_AWAITING=2, READ_SUCCESS=3, WRITE_SUBMITTING=4, WRITE_AWAITING=5, WRITE_SUCCESS=6, FAULT=7.
- IDLE, with i_Request and a load type:
  - Misaligned → FAULT. Misaligned means a half with addr[0]=1, or a word with addr[1:0]!=0.
  - Otherwise → READ_SUBMITTING.
- IDLE, with i_Request and a store type: same misalignment check, otherwise → WRITE_SUBMITTING.
- IDLE, with i_Request and any other code: o_Done=1, o_Error=0 for one cycle, no bus activity, stay in IDLE.
- Bus addresses: araddr and awaddr are the latched address with bits [1:0] cleared.
- READ_SUBMITTING: arvalid=1; on arready → READ_AWAITING.
- READ_AWAITING: rready=1; on rvalid:
  - Lane = rdata >> (8*addr[1:0]).
  - Byte loads take lane[7:0]; half loads take lane[15:0]; sign-extend for the signed variants, zero-extend otherwise.
  - Register the result into o_Data and latch rresp!=0 as the error flag → READ_SUCCESS.
- WRITE_SUBMITTING:
  - awvalid and wvalid are both raised on entry.
  - Each one drops independently after its own handshake; internal aw_done and w_done flags track this.
  - When both are done, including in the same cycle → WRITE_AWAITING.
  - wdata: byte stores use {4{d[7:0]}}, half stores use {2{d[15:0]}}, word stores use d.
  - wstrb: byte stores use 4'b0001<<addr[1:0], half stores use 4'b0011<<{addr[1],1'b0}, word stores use 4'b1111.
- WRITE_AWAITING: bready=1; on bvalid, latch bresp!=0 as the error flag → WRITE_SUCCESS.
- READ_SUCCESS and WRITE_SUCCESS: o_Done=1, o_Error=latched flag → IDLE.
- FAULT: o_Done=1, o_Error=1, all valid/ready outputs low → IDLE.
- Watchdog:
  - The counter clears on entry to states 1, 2, 4 and 5, and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES → FAULT.
  - After a timeout the slave must be reset before further use; late responses are ignored because rready and bready are low.
- o_Data is not updated by stores, faults or error-free non-load completions. A load with an error RRESP still updates o_Data.

## Timing
- Reset values: state IDLE; o_Data=0; o_Done, o_Error and o_Busy 0; all valid and ready outputs 0; addresses, wdata and wstrb 0; internal flags and counter 0.
- Reset mid-transaction returns to IDLE next cycle and drops all valids; outstanding bus state is the system's responsibility.
- Valid and ready outputs are combinational from state and flags only, never from AXI inputs.
- Zero-wait slave:
  - Load: request at cycle N; arvalid at N+1; arready at N+1; rvalid at N+2; o_Done at N+3. Total 3 cycles.
  - Store: AW and W handshake at N+1; bvalid at N+2; o_Done at N+3.
- Misaligned or unknown-type requests: o_Done at N+1 and N respectively.
- i_Request while busy is ignored. The CPU must hold or re-issue after o_Done.
- The next request may be accepted in the cycle after o_Done.

## Test plan
- Word store of 0xDEADBEEF to 0x0010, then word load from 0x0010 → wstrb=4'hF, awaddr=0x0010, o_Data=0xDEADBEEF, o_Error=0, o_Done 3 cycles after each request.
- Byte store of 0x000000A5 to 0x0013 → wdata=0xA5A5A5A5, wstrb=4'b1000. A following signed byte load from 0x0013 gives 0xFFFFFFA5; unsigned gives 0x000000A5.
- Half store of 0x8001 to 0x0022 → wstrb=4'b1100. Signed half load from 0x0022 gives 0xFFFF8001; unsigned half load gives 0x00008001.
- Slave delays awready by 3 cycles but gives wready immediately → wvalid drops after 1 cycle, awvalid holds 3 cycles, bready rises only once both are done, and a single o_Done.
- Word load from 0x0002 → FAULT, o_Done=o_Error=1 at N+1, no arvalid ever. A slave returning RRESP=2'b10 → o_Error=1 with o_Done.
- TIMEOUT_CYCLES=8, slave never asserts arready → arvalid for 8 cycles, then FAULT and o_Error pulse. Reset asserted mid-WRITE_AWAITING → IDLE with bready=0 the next cycle.

Source files
------------

// File: rtl/memory_axil_lsu.sv
// Load/store unit: one CPU memory request becomes one AXI4-Lite master transaction,
// with byte-lane steering, sign extension, misalignment/response errors and a watchdog.
module memory_axil_lsu #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,

    input  logic                  i_Request,
    input  logic [3:0]            i_Load_Store_Type,
    input  logic [31:0]           i_Addr,
    input  logic [31:0]           i_Data,
    output logic [31:0]           o_Data,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic                  o_Busy,
    output logic [2:0]            o_State,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    localparam int unsigned XLEN         = 32;
    localparam int unsigned LS_SEL_WIDTH = 3;

    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD          = 4'd0;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF          = 4'd1;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF_UNSIGNED = 4'd2;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE          = 4'd3;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE_UNSIGNED = 4'd4;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_WORD         = 4'd5;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_HALF         = 4'd6;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_BYTE         = 4'd7;

    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StReadSubmit   = 3'd1,
        StReadAwait    = 3'd2,
        StReadSuccess  = 3'd3,
        StWriteSubmit  = 3'd4,
        StWriteAwait   = 3'd5,
        StWriteSuccess = 3'd6,
        StFault        = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [LS_SEL_WIDTH:0] type_q;
    logic [1:0]            addr_lo_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  err_q;
    logic [31:0]           wdog_q;

    logic        req_load, req_store, req_half, req_word;
    logic        misaligned, accept;
    logic        aw_hs, w_hs, timeout;
    logic [31:0] store_wdata;
    logic [3:0]  store_wstrb;
    logic [31:0] lane, load_result;
    logic [ADDR_WIDTH-1:0] bus_addr;

    if (ADDR_WIDTH < XLEN) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^i_Addr[XLEN-1:ADDR_WIDTH];
    end

    // Request decode
    always_comb begin
        req_load  = 1'b0;
        req_store = 1'b0;
        req_half  = 1'b0;
        req_word  = 1'b0;
        case (i_Load_Store_Type)
            LS_TYPE_LOAD_WORD:          begin req_load  = 1'b1; req_word = 1'b1; end
            LS_TYPE_LOAD_HALF:          begin req_load  = 1'b1; req_half = 1'b1; end
            LS_TYPE_LOAD_HALF_UNSIGNED: begin req_load  = 1'b1; req_half = 1'b1; end
            LS_TYPE_LOAD_BYTE:          req_load  = 1'b1;
            LS_TYPE_LOAD_BYTE_UNSIGNED: req_load  = 1'b1;
            LS_TYPE_STORE_WORD:         begin req_store = 1'b1; req_word = 1'b1; end
            LS_TYPE_STORE_HALF:         begin req_store = 1'b1; req_half = 1'b1; end
            LS_TYPE_STORE_BYTE:         req_store = 1'b1;
            default: ;
        endcase
    end

    assign misaligned = (req_half && i_Addr[0]) || (req_word && (i_Addr[1:0] != 2'b00));
    assign accept     = (state_q == StIdle) && i_Request && (req_load || req_store) && !misaligned;
    assign bus_addr   = {i_Addr[ADDR_WIDTH-1:2], 2'b00};

    // Store lane replication and strobes
    always_comb begin
        store_wdata = i_Data;
        store_wstrb = 4'b1111;
        if (i_Load_Store_Type == LS_TYPE_STORE_BYTE) begin
            store_wdata = {4{i_Data[7:0]}};
            store_wstrb = 4'b0001 << i_Addr[1:0];
        end else if (i_Load_Store_Type == LS_TYPE_STORE_HALF) begin
            store_wdata = {2{i_Data[15:0]}};
            store_wstrb = 4'b0011 << {i_Addr[1], 1'b0};
        end
    end

    // Load lane extraction and extension
    assign lane = m_axil_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        load_result = lane;
        case (type_q)
            LS_TYPE_LOAD_HALF:          load_result = {{16{lane[15]}}, lane[15:0]};
            LS_TYPE_LOAD_HALF_UNSIGNED: load_result = {16'h0000, lane[15:0]};
            LS_TYPE_LOAD_BYTE:          load_result = {{24{lane[7]}}, lane[7:0]};
            LS_TYPE_LOAD_BYTE_UNSIGNED: load_result = {24'h000000, lane[7:0]};
            default: ;
        endcase
    end

    assign aw_hs   = m_axil_awvalid && m_axil_awready;
    assign w_hs    = m_axil_wvalid && m_axil_wready;
    assign timeout = (TIMEOUT_CYCLES != 0) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (i_Request && (req_load || req_store)) begin
                    if (misaligned)     state_d = StFault;
                    else if (req_load)  state_d = StReadSubmit;
                    else                state_d = StWriteSubmit;
                end
            end
            StReadSubmit: begin
                if (m_axil_arready) state_d = StReadAwait;
                else if (timeout)   state_d = StFault;
            end
            StReadAwait: begin
                if (m_axil_rvalid) state_d = StReadSuccess;
                else if (timeout)  state_d = StFault;
            end
            StWriteSubmit: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWriteAwait;
                else if (timeout)                               state_d = StFault;
            end
            StWriteAwait: begin
                if (m_axil_bvalid) state_d = StWriteSuccess;
                else if (timeout)  state_d = StFault;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on state and flags, never on AXI inputs
    always_comb begin
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        o_Done         = 1'b0;
        o_Error        = 1'b0;
        case (state_q)
            StIdle:         o_Done = i_Request && !req_load && !req_store;
            StReadSubmit:   m_axil_arvalid = 1'b1;
            StReadAwait:    m_axil_rready  = 1'b1;
            StReadSuccess:  begin o_Done = 1'b1; o_Error = err_q; end
            StWriteSubmit:  begin
                m_axil_awvalid = !aw_done_q;
                m_axil_wvalid  = !w_done_q;
            end
            StWriteAwait:   m_axil_bready  = 1'b1;
            StWriteSuccess: begin o_Done = 1'b1; o_Error = err_q; end
            StFault:        begin o_Done = 1'b1; o_Error = 1'b1; end
            default: ;
        endcase
        o_Busy  = (state_q != StIdle);
        o_State = state_q;
    end

    // Datapath, handshake flags and watchdog
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            type_q        <= '0;
            addr_lo_q     <= 2'b00;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            err_q         <= 1'b0;
            wdog_q        <= 32'd0;
            o_Data        <= 32'd0;
            m_axil_araddr <= '0;
            m_axil_awaddr <= '0;
            m_axil_wdata  <= 32'd0;
            m_axil_wstrb  <= 4'b0000;
        end else begin
            if (accept) begin
                type_q    <= i_Load_Store_Type;
                addr_lo_q <= i_Addr[1:0];
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                err_q     <= 1'b0;
                if (req_load) begin
                    m_axil_araddr <= bus_addr;
                end else begin
                    m_axil_awaddr <= bus_addr;
                    m_axil_wdata  <= store_wdata;
                    m_axil_wstrb  <= store_wstrb;
                end
            end

            if (state_q == StWriteSubmit) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end

            if ((state_q == StReadAwait) && m_axil_rvalid) begin
                o_Data <= load_result;
                err_q  <= (m_axil_rresp != 2'b00);
            end

            if ((state_q == StWriteAwait) && m_axil_bvalid) begin
                err_q <= (m_axil_bresp != 2'b00);
            end

            // Counter restarts on every state change and runs only while waiting on the bus
            if (state_d != state_q) begin
                wdog_q <= 32'd0;
            end else if ((state_q == StReadSubmit) || (state_q == StReadAwait) ||
                         (state_q == StWriteSubmit) || (state_q == StWriteAwait)) begin
                wdog_q <= wdog_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_memory_axil_lsu.sv
// Directed bench for memory_axil_lsu: scripted AXI4-Lite slave model plus a scoreboard of
// expected completions popped on each o_Done.
module tb_memory_axil_lsu;

    localparam logic [3:0] LS_LW  = 4'd0;
    localparam logic [3:0] LS_LH  = 4'd1;
    localparam logic [3:0] LS_LHU = 4'd2;
    localparam logic [3:0] LS_LB  = 4'd3;
    localparam logic [3:0] LS_LBU = 4'd4;
    localparam logic [3:0] LS_SW  = 4'd5;
    localparam logic [3:0] LS_SH  = 4'd6;
    localparam logic [3:0] LS_SB  = 4'd7;
    localparam logic [3:0] LS_BAD = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [3:0]  ls_type;
    logic [31:0] addr, wr_in, rd_out;
    logic        done, error, busy;
    logic [2:0]  state;

    logic [15:0] araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    memory_axil_lsu #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_Clock           (clk),
        .i_Reset           (reset),
        .i_Request         (req),
        .i_Load_Store_Type (ls_type),
        .i_Addr            (addr),
        .i_Data            (wr_in),
        .o_Data            (rd_out),
        .o_Done            (done),
        .o_Error           (error),
        .o_Busy            (busy),
        .o_State           (state),
        .m_axil_araddr     (araddr),
        .m_axil_arvalid    (arvalid),
        .m_axil_arready    (arready),
        .m_axil_rdata      (rdata),
        .m_axil_rresp      (rresp),
        .m_axil_rvalid     (rvalid),
        .m_axil_rready     (rready),
        .m_axil_awaddr     (awaddr),
        .m_axil_awvalid    (awvalid),
        .m_axil_awready    (awready),
        .m_axil_wdata      (wdata),
        .m_axil_wstrb      (wstrb),
        .m_axil_wvalid     (wvalid),
        .m_axil_wready     (wready),
        .m_axil_bresp      (bresp),
        .m_axil_bvalid     (bvalid),
        .m_axil_bready     (bready)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          lat;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Slave knobs, written only by the main sequence
    int         ar_delay = 0, aw_delay = 0;
    logic       ar_block = 1'b0, b_block = 1'b0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    // Monitor totals, written only by the monitor
    int          arv_cyc = 0, awv_cyc = 0, wv_cyc = 0, done_cnt = 0, overlap_cnt = 0;
    logic [15:0] last_araddr = '0, last_awaddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // AXI4-Lite slave model with a small word memory
    initial begin : slave
        logic [31:0] mem [0:63];
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s, r_pend, aw_got, w_got;
        logic [15:0] rd_a, wr_a;
        logic [31:0] wr_d;
        logic [3:0]  wr_s;
        int ar_cnt, aw_cnt;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        r_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0;
        rd_a = 0; wr_a = 0; wr_d = 0; wr_s = 0;
        forever begin
            @(posedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            rst_s = reset;
            #1;
            if (rst_s) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                r_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0;
            end else begin
                if (r_hs) rvalid = 0;
                if (b_hs) bvalid = 0;
                if (ar_hs) begin rd_a = araddr; r_pend = 1; arready = 0; ar_cnt = 0; end
                if (aw_hs) begin wr_a = awaddr; aw_got = 1; awready = 0; aw_cnt = 0; end
                if (w_hs)  begin wr_d = wdata; wr_s = wstrb; w_got = 1; wready = 0; end
                if (r_pend && !rvalid) begin
                    rdata = mem[rd_a[7:2]]; rresp = rresp_cfg; rvalid = 1; r_pend = 0;
                end
                if (aw_got && w_got && !bvalid && !b_block) begin
                    for (int i = 0; i < 4; i++)
                        if (wr_s[i]) mem[wr_a[7:2]][8*i +: 8] = wr_d[8*i +: 8];
                    bresp = bresp_cfg; bvalid = 1; aw_got = 0; w_got = 0;
                end
                if (arvalid && !arready && !ar_hs && !ar_block) begin
                    if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
                end
                if (awvalid && !awready && !aw_hs) begin
                    if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
                end
                if (wvalid && !wready && !w_hs) wready = 1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (arvalid) begin arv_cyc++; last_araddr = araddr; end
            if (awvalid) begin awv_cyc++; last_awaddr = awaddr; end
            if (wvalid)  begin wv_cyc++; last_wdata = wdata; last_wstrb = wstrb; end
            if (done) done_cnt++;
            if (bready && (awvalid || wvalid)) overlap_cnt++;
        end
    end

    // Drive one request, wait (bounded) for o_Done, compare against the scoreboard head
    task automatic issue(input string tag, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] d, input int exp_lat, input logic exp_err,
                         input logic chk, input logic [31:0] exp_data);
        exp_t e;
        int   lat;
        logic got, err_seen;
        logic [31:0] data_seen;
        e.tag = tag; e.lat = exp_lat; e.err = exp_err; e.chk_data = chk; e.data = exp_data;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req = 1; ls_type = t; addr = a; wr_in = d;
        lat = 0; got = 0; err_seen = 0; data_seen = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (done) begin
                got = 1; err_seen = error; data_seen = rd_out;
            end else begin
                @(posedge clk); #1;
                req = 0;
                lat++;
            end
        end
        if (req) begin @(posedge clk); #1; req = 0; end
        e = sb_q.pop_front();
        check({e.tag, " done"}, 32'(got), 32'd1);
        check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
        check({e.tag, " error"}, 32'(err_seen), 32'(e.err));
        if (e.chk_data) check({e.tag, " data"}, data_seen, e.data);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 0;
    endtask

    initial begin : main
        int a0, aw0, w0, d0, ov0, n;
        reset = 1; req = 0; ls_type = 0; addr = 0; wr_in = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset o_Data", rd_out, 32'd0);
        check("reset flags", {29'd0, done, error, busy}, 32'd0);
        check("reset valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("reset awaddr/wstrb", {12'd0, awaddr, wstrb}, 32'd0);

        issue("sw 0x10", LS_SW, 32'h10, 32'hDEADBEEF, 3, 0, 0, 0);
        check("sw 0x10 wstrb", 32'(last_wstrb), 32'hF);
        check("sw 0x10 awaddr", 32'(last_awaddr), 32'h10);
        check("sw 0x10 wdata", last_wdata, 32'hDEADBEEF);
        issue("lw 0x10", LS_LW, 32'h10, 0, 3, 0, 1, 32'hDEADBEEF);
        check("lw 0x10 araddr", 32'(last_araddr), 32'h10);

        issue("sb 0x13", LS_SB, 32'h13, 32'h000000A5, 3, 0, 1, 32'hDEADBEEF);
        check("sb 0x13 wdata", last_wdata, 32'hA5A5A5A5);
        check("sb 0x13 wstrb", 32'(last_wstrb), 32'h8);
        check("sb 0x13 awaddr", 32'(last_awaddr), 32'h10);
        issue("lb 0x13", LS_LB, 32'h13, 0, 3, 0, 1, 32'hFFFFFFA5);
        issue("lbu 0x13", LS_LBU, 32'h13, 0, 3, 0, 1, 32'h000000A5);

        issue("sh 0x22", LS_SH, 32'h22, 32'h00008001, 3, 0, 0, 0);
        check("sh 0x22 wstrb", 32'(last_wstrb), 32'hC);
        check("sh 0x22 wdata", last_wdata, 32'h80018001);
        issue("lh 0x22", LS_LH, 32'h22, 0, 3, 0, 1, 32'hFFFF8001);
        issue("lhu 0x22", LS_LHU, 32'h22, 0, 3, 0, 1, 32'h00008001);
        issue("lw 0x10 merged", LS_LW, 32'h10, 0, 3, 0, 1, 32'hA5ADBEEF);

        a0 = arv_cyc; aw0 = awv_cyc;
        issue("unknown type", LS_BAD, 32'h10, 0, 0, 0, 1, 32'hA5ADBEEF);
        check("unknown bus idle", 32'((arv_cyc - a0) + (awv_cyc - aw0)), 32'd0);

        // Slow AW channel, immediate W channel
        aw_delay = 2;
        a0 = arv_cyc; aw0 = awv_cyc; w0 = wv_cyc; d0 = done_cnt; ov0 = overlap_cnt;
        issue("sw slow aw", LS_SW, 32'h30, 32'h12345678, 5, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("slow aw awvalid cycles", 32'(awv_cyc - aw0), 32'd3);
        check("slow aw wvalid cycles", 32'(wv_cyc - w0), 32'd1);
        check("slow aw bready early", 32'(overlap_cnt - ov0), 32'd0);
        check("slow aw done pulses", 32'(done_cnt - d0), 32'd1);
        aw_delay = 0;
        issue("lw 0x30", LS_LW, 32'h30, 0, 3, 0, 1, 32'h12345678);

        a0 = arv_cyc; aw0 = awv_cyc;
        issue("lw misaligned", LS_LW, 32'h02, 0, 1, 1, 1, 32'h12345678);
        issue("lh misaligned", LS_LH, 32'h23, 0, 1, 1, 0, 0);
        issue("sw misaligned", LS_SW, 32'h41, 32'h1, 1, 1, 0, 0);
        check("misaligned bus idle", 32'((arv_cyc - a0) + (awv_cyc - aw0)), 32'd0);

        rresp_cfg = 2'b10;
        issue("lw rresp err", LS_LW, 32'h10, 0, 3, 1, 1, 32'hA5ADBEEF);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b10;
        issue("sw bresp err", LS_SW, 32'h40, 32'h55, 3, 1, 0, 0);
        bresp_cfg = 2'b00;

        ar_block = 1;
        a0 = arv_cyc;
        issue("lw timeout", LS_LW, 32'h10, 0, 9, 1, 1, 32'hA5ADBEEF);
        check("timeout arvalid cycles", 32'(arv_cyc - a0), 32'd8);
        ar_block = 0;
        do_reset();

        // Reset while waiting for BVALID
        b_block = 1;
        @(posedge clk); #1;
        req = 1; ls_type = LS_SW; addr = 32'h50; wr_in = 32'h77;
        @(posedge clk); #1;
        req = 0;
        n = 0;
        while (state != 3'd5 && n < 20) begin @(posedge clk); #1; n++; end
        check("reach write awaiting", 32'(state), 32'd5);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("mid-reset state", 32'(state), 32'd0);
        check("mid-reset bready/busy", {30'd0, bready, busy}, 32'd0);
        check("mid-reset o_Data", rd_out, 32'd0);
        b_block = 0;

        issue("sw after reset", LS_SW, 32'h50, 32'hCAFEF00D, 3, 0, 0, 0);
        issue("lw after reset", LS_LW, 32'h50, 0, 3, 0, 1, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
